// File: rtl/can_bit_timing_ctrl.sv
// CAN nominal bit timing: tq prescaler plus SYNC/TSEG1/TSEG2 sequencer with hard sync and resync.
// Latency: seg_state/tx_point/sample_point/resync_event are registered (high on the first clock of the entered segment); tq_tick is decoded from the prescaler.
// Backpressure: none; free-runs while enable=1 and is held in IDLE otherwise.
module can_bit_timing_ctrl #(
  parameter int BRP_W   = 6,
  parameter int TSEG1_W = 4,
  parameter int TSEG2_W = 3,
  parameter int SJW_W   = 2
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               enable,
  input  logic [BRP_W-1:0]   brp,
  input  logic [TSEG1_W-1:0] tseg1,
  input  logic [TSEG2_W-1:0] tseg2,
  input  logic [SJW_W-1:0]   sjw,
  input  logic               hard_sync_en,
  input  logic               rx_falling_edge,
  input  logic               rx_bit,
  output logic [1:0]         seg_state,
  output logic               tq_tick,
  output logic               sample_point,
  output logic               sampled_bit,
  output logic               tx_point,
  output logic               resync_event
);
  // Segment counter must hold TSEG1 plus the largest phase1 extension.
  localparam int SEG_W = TSEG1_W + 2;
  localparam int EXT_W = SJW_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_TSEG1 = 2'd2,
    ST_TSEG2 = 2'd3
  } seg_e;

  seg_e               state_q, state_d;
  logic [BRP_W-1:0]   presc_q, presc_d;
  logic [SEG_W-1:0]   seg_cnt_q, seg_cnt_d;
  logic [EXT_W-1:0]   ext_q, ext_d;
  logic [SEG_W-1:0]   t2_len_q, t2_len_d;
  logic               resync_done_q, resync_done_d;
  logic [BRP_W-1:0]   brp_s_q, brp_s_d;
  logic [TSEG1_W-1:0] tseg1_s_q, tseg1_s_d;
  logic [TSEG2_W-1:0] tseg2_s_q, tseg2_s_d;
  logic [SJW_W-1:0]   sjw_s_q, sjw_s_d;
  logic               tx_point_q, tx_point_d;
  logic               sample_point_q, sample_point_d;
  logic               resync_event_q, resync_event_d;
  logic               sampled_bit_q, sampled_bit_d;

  logic               tick;
  logic               t1_end;
  logic               edge_ok;
  logic [SEG_W-1:0]   seg_inc;
  logic [SEG_W-1:0]   sjw_len;
  logic [SEG_W-1:0]   t2_nom;
  logic [SEG_W-1:0]   t2_floor;
  logic [SEG_W-1:0]   t2_cut;

  assign tick     = (state_q != ST_IDLE) && (presc_q == brp_s_q);
  assign seg_inc  = seg_cnt_q + SEG_W'(1);
  assign sjw_len  = SEG_W'(sjw_s_q) + SEG_W'(1);
  assign t2_nom   = SEG_W'(tseg2_s_q) + SEG_W'(1);
  // Shortest TSEG2 a resync may leave; the tq holding the edge still completes.
  assign t2_floor = (t2_nom > sjw_len) ? (t2_nom - sjw_len) : '0;
  assign t2_cut   = (seg_inc > t2_floor) ? seg_inc : t2_floor;
  assign t1_end   = (seg_cnt_q == (SEG_W'(tseg1_s_q) + SEG_W'(ext_q)));
  assign edge_ok  = rx_falling_edge && !hard_sync_en && !resync_done_q;

  // Next-state: enable gate, hard sync, then tq-paced segment walk with resync.
  always_comb begin
    state_d        = state_q;
    presc_d        = presc_q;
    seg_cnt_d      = seg_cnt_q;
    ext_d          = ext_q;
    t2_len_d       = t2_len_q;
    resync_done_d  = resync_done_q;
    sampled_bit_d  = sampled_bit_q;
    brp_s_d        = brp_s_q;
    tseg1_s_d      = tseg1_s_q;
    tseg2_s_d      = tseg2_s_q;
    sjw_s_d        = sjw_s_q;
    tx_point_d     = 1'b0;
    sample_point_d = 1'b0;
    resync_event_d = 1'b0;

    if (!enable) begin
      state_d       = ST_IDLE;
      presc_d       = '0;
      seg_cnt_d     = '0;
      ext_d         = '0;
      t2_len_d      = '0;
      resync_done_d = 1'b0;
      sampled_bit_d = 1'b1;
    end else if ((state_q == ST_IDLE) || (hard_sync_en && rx_falling_edge)) begin
      // Start of a bit from idle, or hard sync overriding any pending tq_tick.
      state_d    = ST_SYNC;
      presc_d    = '0;
      seg_cnt_d  = '0;
      ext_d      = '0;
      tx_point_d = 1'b1;
    end else begin
      presc_d = tick ? '0 : (presc_q + BRP_W'(1));
      unique case (state_q)
        ST_SYNC: begin
          if (tick) begin
            state_d   = ST_TSEG1;
            seg_cnt_d = '0;
          end
        end
        ST_TSEG1: begin
          // An edge on the tick that closes TSEG1 arrives too late to lengthen it.
          if (edge_ok && !(tick && t1_end)) begin
            ext_d          = (seg_inc < sjw_len) ? EXT_W'(seg_inc) : EXT_W'(sjw_len);
            resync_done_d  = 1'b1;
            resync_event_d = 1'b1;
          end
          if (tick) begin
            if (t1_end) begin
              state_d        = ST_TSEG2;
              seg_cnt_d      = '0;
              t2_len_d       = t2_nom;
              sample_point_d = 1'b1;
              sampled_bit_d  = rx_bit;
              resync_done_d  = 1'b0;
            end else begin
              seg_cnt_d = seg_inc;
            end
          end
        end
        ST_TSEG2: begin
          if (edge_ok) begin
            t2_len_d       = t2_cut;
            resync_done_d  = 1'b1;
            resync_event_d = 1'b1;
          end
          if (tick) begin
            if (seg_inc >= t2_len_d) begin
              state_d    = ST_SYNC;
              seg_cnt_d  = '0;
              ext_d      = '0;
              tx_point_d = 1'b1;
            end else begin
              seg_cnt_d = seg_inc;
            end
          end
        end
        default: begin
        end
      endcase
    end

    // Timing config is sampled once per bit so mid-bit writes take effect next bit.
    if (tx_point_d) begin
      brp_s_d   = brp;
      tseg1_s_d = tseg1;
      tseg2_s_d = tseg2;
      sjw_s_d   = sjw;
    end
  end

  // State, counters, shadow config and registered strobes.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      presc_q        <= '0;
      seg_cnt_q      <= '0;
      ext_q          <= '0;
      t2_len_q       <= '0;
      resync_done_q  <= 1'b0;
      brp_s_q        <= '0;
      tseg1_s_q      <= '0;
      tseg2_s_q      <= '0;
      sjw_s_q        <= '0;
      tx_point_q     <= 1'b0;
      sample_point_q <= 1'b0;
      resync_event_q <= 1'b0;
      sampled_bit_q  <= 1'b1;
    end else begin
      state_q        <= state_d;
      presc_q        <= presc_d;
      seg_cnt_q      <= seg_cnt_d;
      ext_q          <= ext_d;
      t2_len_q       <= t2_len_d;
      resync_done_q  <= resync_done_d;
      brp_s_q        <= brp_s_d;
      tseg1_s_q      <= tseg1_s_d;
      tseg2_s_q      <= tseg2_s_d;
      sjw_s_q        <= sjw_s_d;
      tx_point_q     <= tx_point_d;
      sample_point_q <= sample_point_d;
      resync_event_q <= resync_event_d;
      sampled_bit_q  <= sampled_bit_d;
    end
  end

  assign seg_state    = state_q;
  assign tq_tick      = tick;
  assign sample_point = sample_point_q;
  assign sampled_bit  = sampled_bit_q;
  assign tx_point     = tx_point_q;
  assign resync_event = resync_event_q;

endmodule

// File: tb/tb_can_bit_timing_ctrl.sv
// Bench for can_bit_timing_ctrl: directed bit-timing scenarios plus randomized configs and edge positions.
// Expected strobe positions come from a per-bit arithmetic model of segment lengths.
// Inputs change 1 time unit after each rising edge; outputs are sampled at the same point.
module tb_can_bit_timing_ctrl;
  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic [5:0] brp = '0;
  logic [3:0] tseg1 = '0;
  logic [2:0] tseg2 = '0;
  logic [1:0] sjw = '0;
  logic       hard_sync_en = 1'b0;
  logic       rx_falling_edge = 1'b0;
  logic       rx_bit = 1'b1;
  logic [1:0] seg_state;
  logic       tq_tick, sample_point, sampled_bit, tx_point, resync_event;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  can_bit_timing_ctrl #(.BRP_W(6), .TSEG1_W(4), .TSEG2_W(3), .SJW_W(2)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .brp(brp), .tseg1(tseg1),
    .tseg2(tseg2), .sjw(sjw), .hard_sync_en(hard_sync_en), .rx_falling_edge(rx_falling_edge),
    .rx_bit(rx_bit), .seg_state(seg_state), .tq_tick(tq_tick), .sample_point(sample_point),
    .sampled_bit(sampled_bit), .tx_point(tx_point), .resync_event(resync_event)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  // Enable from IDLE with the given config; returns observing the tx_point cycle (rel 0).
  task automatic start_bit(input int b, input int t1, input int t2, input int s, input string tag);
    enable = 1'b0; rx_falling_edge = 1'b0; hard_sync_en = 1'b0;
    step(); step();
    brp = 6'(b); tseg1 = 4'(t1); tseg2 = 3'(t2); sjw = 2'(s);
    enable = 1'b1;
    step();
    chk({tag, "_start_tx"}, 32'(tx_point), 32'd1);
  endtask

  // One bit with up to two resync edges (cycle offsets from tx_point, -1 = none, e1 < e2).
  task automatic run_bit(input int b, input int t1, input int t2, input int s,
                         input int e1, input int e2, input string tag);
    int tq, T1, T2, SJ, fl, ext, len, nev, ev_first, sp_exp, tx_exp, e, q, k;
    int sp_obs, tx_obs, ev_cnt, ev_obs, shape_err, st_exp;
    int ed[2];
    bit pre, post;
    logic sb_obs;
    logic hist [4096];
    tq = b + 1; T1 = t1 + 1; T2 = t2 + 1; SJ = s + 1;
    fl = (T2 > SJ) ? T2 - SJ : 0;
    ext = 0; len = T2; pre = 0; post = 0; nev = 0; ev_first = -1;
    ed[0] = e1; ed[1] = e2;
    // One resync per sample-point window: edges before the sample point share one, edges after share another.
    for (int i = 0; i < 2; i++) begin
      sp_exp = tq * (1 + T1 + ext);
      tx_exp = sp_exp + tq * len;
      e = ed[i];
      if (e >= 0 && e < tx_exp) begin
        q = e / tq;
        if (e < sp_exp) begin
          if (!pre && q >= 1 && !(q == T1 && (e % tq) == tq - 1)) begin
            ext = (q < SJ) ? q : SJ;
            pre = 1; nev++;
            if (ev_first < 0) ev_first = e + 1;
          end
        end else if (!post) begin
          k = (e - sp_exp) / tq;
          len = (k + 1 > fl) ? k + 1 : fl;
          post = 1; nev++;
          if (ev_first < 0) ev_first = e + 1;
        end
      end
    end
    sp_exp = tq * (1 + T1 + ext);
    tx_exp = sp_exp + tq * len;

    start_bit(b, t1, t2, s, tag);
    sp_obs = -1; tx_obs = -1; ev_cnt = 0; ev_obs = -1; shape_err = 0; sb_obs = 1'bx;
    for (int rel = 0; rel < 4000; rel++) begin
      if (resync_event === 1'b1) begin
        ev_cnt++;
        if (ev_obs < 0) ev_obs = rel;
      end
      if (rel > 0 && tx_point === 1'b1) begin
        tx_obs = rel;
        break;
      end
      if (sample_point === 1'b1 && sp_obs < 0) begin
        sp_obs = rel;
        sb_obs = sampled_bit;
      end
      st_exp = (rel < tq) ? 1 : (rel < sp_exp) ? 2 : 3;
      if (seg_state !== st_exp[1:0] || tq_tick !== ((rel % tq) == (tq - 1))) shape_err++;
      rx_falling_edge = (rel == e1) || (rel == e2);
      rx_bit = 1'($urandom);
      hist[rel] = rx_bit;
      step();
    end
    rx_falling_edge = 1'b0;
    chk({tag, "_sample_point"}, sp_obs, sp_exp);
    chk({tag, "_tx_point"}, tx_obs, tx_exp);
    chk({tag, "_resync_cnt"}, ev_cnt, nev);
    chk({tag, "_resync_cycle"}, ev_obs, ev_first);
    chk({tag, "_sampled_bit"}, 32'(sb_obs), 32'(hist[sp_exp - 1]));
    chk({tag, "_seg_shape"}, shape_err, 0);
  endtask

  // Hard sync at cycle e of a bit with the default config.
  task automatic hs_test(input int e, input string tag);
    int tx_obs, sp_obs, ev;
    tx_obs = -1; sp_obs = -1; ev = 0;
    start_bit(1, 5, 2, 1, tag);
    hard_sync_en = 1'b1;
    for (int rel = 0; rel < 200; rel++) begin
      if (resync_event === 1'b1) ev++;
      if (rel > 0 && tx_point === 1'b1 && tx_obs < 0) tx_obs = rel;
      if (sample_point === 1'b1 && sp_obs < 0 && tx_obs >= 0) sp_obs = rel;
      if (sp_obs >= 0) break;
      rx_falling_edge = (rel == e);
      step();
    end
    rx_falling_edge = 1'b0;
    hard_sync_en = 1'b0;
    chk({tag, "_tx_point"}, tx_obs, e + 1);
    chk({tag, "_sample_point"}, sp_obs, e + 1 + 2 * 7);
    chk({tag, "_no_resync"}, ev, 0);
  endtask

  initial begin
    int b, t1, t2, s, nom, e1, e2;
    // Reset state.
    step(); step();
    chk("rst_seg_state", 32'(seg_state), 32'd0);
    chk("rst_tq_tick", 32'(tq_tick), 32'd0);
    chk("rst_sample_point", 32'(sample_point), 32'd0);
    chk("rst_tx_point", 32'(tx_point), 32'd0);
    chk("rst_sampled_bit", 32'(sampled_bit), 32'd1);
    chk("rst_resync_event", 32'(resync_event), 32'd0);
    reset_n = 1'b1;
    step();

    // Default config: tq = 2 clocks, bit = 20 clocks, sample at 14.
    run_bit(1, 5, 2, 1, -1, -1, "free_run");
    run_bit(1, 5, 2, 1, 8, -1, "t1_resync_c3");
    run_bit(1, 5, 2, 1, 14, -1, "t2_resync_c0");
    run_bit(1, 5, 2, 1, 8, 12, "two_edges");
    run_bit(1, 5, 2, 1, 1, -1, "sync_edge");
    run_bit(1, 5, 2, 1, 13, -1, "t1_end_edge");
    run_bit(1, 5, 2, 1, 19, -1, "t2_last_clk");
    hs_test(8, "hard_sync");
    hs_test(9, "hard_sync_tick");

    // enable drop mid-TSEG1 after a dominant sample.
    start_bit(1, 5, 2, 1, "en_drop");
    rx_bit = 1'b0;
    for (int r = 0; r < 15; r++) step();
    chk("en_drop_sampled0", 32'(sampled_bit), 32'd0);
    for (int r = 15; r < 26; r++) step();
    chk("en_drop_in_tseg1", 32'(seg_state), 32'd2);
    enable = 1'b0;
    step();
    chk("en_drop_idle", 32'(seg_state), 32'd0);
    chk("en_drop_strobes", {29'd0, tx_point, sample_point, resync_event}, 32'd0);
    chk("en_drop_tick", 32'(tq_tick), 32'd0);
    chk("en_drop_sampled1", 32'(sampled_bit), 32'd1);
    enable = 1'b1;
    step();
    chk("en_restart_tx", 32'(tx_point), 32'd1);

    // Asynchronous reset mid-TSEG1 after a dominant sample.
    for (int r = 0; r < 15; r++) step();
    chk("rst_mid_sampled0", 32'(sampled_bit), 32'd0);
    for (int r = 15; r < 26; r++) step();
    reset_n = 1'b0;
    #1;
    chk("rst_mid_idle", 32'(seg_state), 32'd0);
    chk("rst_mid_sampled1", 32'(sampled_bit), 32'd1);
    chk("rst_mid_strobes", {30'd0, tx_point, sample_point}, 32'd0);
    step();
    reset_n = 1'b1;
    step();
    chk("rst_restart_tx", 32'(tx_point), 32'd1);
    rx_bit = 1'b1;

    // Randomized configs and edge positions.
    for (int n = 0; n < 40; n++) begin
      b = int'($urandom_range(7, 0));
      t1 = int'($urandom_range(15, 0));
      t2 = int'($urandom_range(7, 0));
      s = int'($urandom_range(3, 0));
      nom = (b + 1) * (1 + t1 + 1 + t2 + 1);
      e1 = ($urandom_range(9, 0) == 0) ? -1 : int'($urandom_range(nom - 1, 0));
      e2 = -1;
      if (e1 >= 0 && e1 < nom - 1 && $urandom_range(1, 0) == 1)
        e2 = int'($urandom_range(nom - 1, e1 + 1));
      run_bit(b, t1, t2, s, e1, e2, "rand");
    end

    enable = 1'b0;
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
